// File: rtl/rx_det_sched.sv
// Receiver-detect scheduler: walks enabled lanes one at a time through a
// 4-phase req/ack handshake with the analog detect model, with timeout and retry.
module rx_det_sched #(
    parameter int NUM_LANES = 4,
    parameter int TO_CYCLES = 1024,
    parameter int RETRY_MAX = 2,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_LANES-1:0] lane_en,
    output logic [NUM_LANES-1:0] rx_det_seq_req,
    input  logic [NUM_LANES-1:0] rx_det_seq_ack,
    input  logic [NUM_LANES-1:0] rx_det_valid,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_LANES-1:0] det_mask,
    output logic [NUM_LANES-1:0] timeout_mask
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int RW = $clog2(RETRY_MAX + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACK, S_WAIT_DROP, S_GAP, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [NUM_LANES-1:0] en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [NUM_LANES-1:0] det_q, det_d;
    logic [NUM_LANES-1:0] to_q, to_d;

    logic                 first_vld, nxt_vld, adv;
    logic [LW-1:0]        first_lane, nxt_lane;
    logic [CNT_W-1:0]     cnt_inc;
    logic [RW-1:0]        retry_inc;
    logic                 ack_cur, to_hit;

    // Lowest enabled lane for a new pass, and the next enabled lane above the current one
    always_comb begin
        first_vld  = 1'b0;
        first_lane = '0;
        nxt_vld    = 1'b0;
        nxt_lane   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_en[i]) begin
                first_vld  = 1'b1;
                first_lane = LW'(i);
            end
            if (en_q[i] && (i > int'(lane_q))) begin
                nxt_vld  = 1'b1;
                nxt_lane = LW'(i);
            end
        end
    end

    // Next-state logic: handshake sequencing, timeout/retry, mask updates
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        det_d     = det_q;
        to_d      = to_q;
        adv       = 1'b0;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        retry_inc = retry_q + 1'b1;
        ack_cur   = rx_det_seq_ack[lane_q];
        to_hit    = (cnt_q >= CNT_W'(TO_CYCLES - 1));

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        en_d    = lane_en;
                        det_d   = '0;
                        to_d    = '0;
                        retry_d = '0;
                        lane_d  = first_lane;
                        state_d = first_vld ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    // The REQ cycle is the first cycle of the ack window
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_cur) begin
                        det_d[lane_q] = rx_det_valid[lane_q];
                        cnt_d         = '0;
                        state_d       = S_WAIT_DROP;
                    end else if (to_hit) begin
                        retry_d = retry_inc;
                        if (retry_inc <= RW'(RETRY_MAX)) begin
                            state_d = S_GAP;
                        end else begin
                            to_d[lane_q] = 1'b1;
                            adv          = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WAIT_DROP: begin
                    if (!ack_cur) begin
                        adv = 1'b1;
                    end else if (to_hit) begin
                        to_d[lane_q] = 1'b1;
                        adv          = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_GAP:   state_d = S_REQ;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (adv) begin
                retry_d = '0;
                lane_d  = nxt_lane;
                state_d = nxt_vld ? S_REQ : S_DONE;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            en_q    <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            det_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            det_q   <= det_d;
            to_q    <= to_d;
        end
    end

    assign rx_det_seq_req = ((state_q == S_REQ) || (state_q == S_WAIT_ACK))
                          ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << lane_q)
                          : '0;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign det_mask     = det_q;
    assign timeout_mask = to_q;

endmodule
